dct2d_coeff_mac: RTL and testbench

Streaming 2-D DCT-II coefficient engine: for a requested frequency pair (k1,k2), it accepts one N×N pixel block in raster order. It multiplies each sample by the matching separable cosine term, accumulates, and returns one rounded coefficient. It generalises the fixed per-(k1,k2) cosine tables to any block size, fractional precision and frequency pair, and adds a start/valid/ready sequencer. It sits between the block-buffer reader and the coefficient quantiser in the DCT datapath.

---
 rtl/dct_pkg.sv | 63 ++++++
 rtl/dct_cos2d_lut.sv | 51 +++++
 rtl/dct2d_coeff_mac.sv | 167 ++++++++++++++++
 tb/tb_dct2d_coeff_mac.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dct_pkg
//  Purpose  : Shared types and elaboration-time helpers for the 2-D DCT-II
//             coefficient engine: width derivation, FSM state encoding and the
//             separable cosine-product generator used to fill the lookup table.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dct_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam real PI = 3.14159265358979323846;

    // Signed cosine term: magnitude reaches 2^FRAC_BITS, so one integer bit
    // plus a sign bit on top of the fraction.
    function automatic int cos_w(input int frac_bits);
        return frac_bits + 2;
    endfunction

    // Level-shifted pixel, signed.
    function automatic int x_w(input int data_w);
        return data_w + 1;
    endfunction

    // Product width plus log2(N*N) growth bits so N*N worst-case products
    // can never overflow the accumulator.
    function automatic int acc_w(input int data_w, input int frac_bits, input int n);
        return x_w(data_w) + cos_w(frac_bits) + 2 * $clog2(n);
    endfunction

    function automatic int out_w(input int data_w, input int frac_bits, input int n);
        return acc_w(data_w, frac_bits, n) - frac_bits;
    endfunction

    // cos((2n1+1)k1*pi/2N) * cos((2n2+1)k2*pi/2N) scaled by 2^frac_bits.
    // Elaboration only. The scaled product is taken toward zero; the tiny bias
    // keeps values that are exact in theory (e.g. cos(pi/4)^2 = 0.5) from
    // dropping one LSB because of double-precision noise in $cos. This yields
    // the established table rows, e.g. N=8, (2,6), n1=0:
    // 90,-218,218,-90,-90,218,-218,90.
    function automatic int cos_term(input int n, input int frac_bits,
                                    input int k1, input int k2,
                                    input int n1, input int n2);
        real a;
        real b;
        real v;
        a = $cos($itor((2 * n1 + 1) * k1) * PI / $itor(2 * n));
        b = $cos($itor((2 * n2 + 1) * k2) * PI / $itor(2 * n));
        v = a * b * $itor(1 << frac_bits);
        if (v >= 0.0) begin
            return $rtoi(v + 1.0e-9);
        end
        return -$rtoi(-v + 1.0e-9);
    endfunction

endpackage : dct_pkg
`default_nettype wire

// File: rtl/dct_cos2d_lut.sv
`default_nettype none
// ============================================================================
//  Module   : dct_cos2d_lut
//  Purpose  : Combinational lookup of the separable 2-D cosine product for a
//             frequency pair (k1,k2) at sample position (n1,n2). The table is
//             fully constant and built at elaboration.
//  Ports    : k1_i, k2_i   frequency pair
//             n1_i, n2_i   sample row / column
//             cos_term_o   signed cosine product, FRAC_BITS fractional bits
//  Revision : 1.0 - initial release
// ============================================================================
module dct_cos2d_lut
    import dct_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int FRAC_BITS = 8,
    localparam int LOG2N     = $clog2(N),
    localparam int COS_W     = cos_w(FRAC_BITS)
) (
    input  logic [LOG2N-1:0]        k1_i,
    input  logic [LOG2N-1:0]        k2_i,
    input  logic [LOG2N-1:0]        n1_i,
    input  logic [LOG2N-1:0]        n2_i,
    output logic signed [COS_W-1:0] cos_term_o
);

    localparam int IDX_W = 4 * LOG2N;
    localparam int DEPTH = 1 << IDX_W;

    logic signed [COS_W-1:0] tab [DEPTH];
    logic [IDX_W-1:0]        idx;

    // Index layout {k1,k2,n1,n2}; N is a power of two so every index is used.
    assign idx = {k1_i, k2_i, n1_i, n2_i};

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_tab
            localparam int K1 = (i >> (3 * LOG2N)) & (N - 1);
            localparam int K2 = (i >> (2 * LOG2N)) & (N - 1);
            localparam int N1 = (i >> LOG2N) & (N - 1);
            localparam int N2 = i & (N - 1);
            localparam logic signed [COS_W-1:0] VAL =
                COS_W'(cos_term(N, FRAC_BITS, K1, K2, N1, N2));
            assign tab[i] = VAL;
        end
    endgenerate

    assign cos_term_o = tab[idx];

endmodule : dct_cos2d_lut
`default_nettype wire

// File: rtl/dct2d_coeff_mac.sv
`default_nettype none
// ============================================================================
//  Module   : dct2d_coeff_mac
//  Purpose  : Streaming 2-D DCT-II coefficient engine. After a start request
//             latches (k1,k2), one N x N pixel block is accepted in raster
//             order, each sample is multiplied by its cosine product and
//             accumulated, and one rounded coefficient is presented on a
//             valid/ready output.
//  Ports    : clk, rst            clock, asynchronous active-high reset
//             start_i, k1_i, k2_i coefficient request and frequency pair
//             busy_o              high while accumulating or holding a result
//             s_valid_i/s_data_i/s_ready_o   pixel stream in
//             m_valid_o/m_data_o/m_ready_i   coefficient out
//  Revision : 1.0 - initial release
// ============================================================================
module dct2d_coeff_mac
    import dct_pkg::*;
#(
    parameter  int N           = 8,
    parameter  int DATA_W      = 8,
    parameter  int FRAC_BITS   = 8,
    parameter  int LEVEL_SHIFT = 1,
    localparam int LOG2N       = $clog2(N),
    localparam int COS_W       = cos_w(FRAC_BITS),
    localparam int X_W         = x_w(DATA_W),
    localparam int ACC_W       = acc_w(DATA_W, FRAC_BITS, N),
    localparam int OUT_W       = out_w(DATA_W, FRAC_BITS, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [LOG2N-1:0]        k1_i,
    input  logic [LOG2N-1:0]        k2_i,
    output logic                    busy_o,
    input  logic                    s_valid_i,
    input  logic [DATA_W-1:0]       s_data_i,
    output logic                    s_ready_o,
    output logic                    m_valid_o,
    output logic signed [OUT_W-1:0] m_data_o,
    input  logic                    m_ready_i
);

    localparam logic [LOG2N-1:0] N_MAX  = LOG2N'(N - 1);
    localparam logic [X_W-1:0]   OFFSET = (LEVEL_SHIFT != 0) ? (X_W'(1) << (DATA_W - 1)) : '0;
    localparam logic [ACC_W-1:0] HALF   = ACC_W'(1) << (FRAC_BITS - 1);

    state_t                  state_q, state_d;
    logic [LOG2N-1:0]        k1_q, k1_d;
    logic [LOG2N-1:0]        k2_q, k2_d;
    logic [LOG2N-1:0]        n1_q, n1_d;
    logic [LOG2N-1:0]        n2_q, n2_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] m_data_q, m_data_d;

    logic signed [COS_W-1:0]     cos_term;
    logic signed [X_W-1:0]       x;
    logic signed [X_W+COS_W-1:0] prod;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [ACC_W-1:0]     rounded;
    logic                        last_sample;

    dct_cos2d_lut #(
        .N         (N),
        .FRAC_BITS (FRAC_BITS)
    ) u_lut (
        .k1_i       (k1_q),
        .k2_i       (k2_q),
        .n1_i       (n1_q),
        .n2_i       (n2_q),
        .cos_term_o (cos_term)
    );

    // Zero-extend then subtract the mid-scale offset; the X_W-bit result is
    // the correct two's-complement sample in both level-shift modes.
    assign x           = $signed({1'b0, s_data_i} - OFFSET);
    assign prod        = x * cos_term;
    assign acc_next    = acc_q + ACC_W'(prod);
    assign rounded     = acc_next + $signed(HALF);
    assign last_sample = (n1_q == N_MAX) && (n2_q == N_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k1_q     <= '0;
            k2_q     <= '0;
            n1_q     <= '0;
            n2_q     <= '0;
            acc_q    <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            n1_q     <= n1_d;
            n2_q     <= n2_d;
            acc_q    <= acc_d;
            m_data_q <= m_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k1_d     = k1_q;
        k2_d     = k2_q;
        n1_d     = n1_q;
        n2_d     = n2_q;
        acc_d    = acc_q;
        m_data_d = m_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    k1_d    = k1_i;
                    k2_d    = k2_i;
                    n1_d    = '0;
                    n2_d    = '0;
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                if (s_valid_i) begin
                    acc_d = acc_next;
                    // Counters wrap to zero on the final sample, ready for the
                    // next block without an explicit clear.
                    if (n2_q == N_MAX) begin
                        n2_d = '0;
                        n1_d = n1_q + 1'b1;
                    end else begin
                        n2_d = n2_q + 1'b1;
                    end
                    if (last_sample) begin
                        m_data_d = OUT_W'(rounded >>> FRAC_BITS);
                        state_d  = DONE;
                    end
                end
            end

            DONE: begin
                if (m_ready_i) begin
                    if (start_i) begin
                        k1_d    = k1_i;
                        k2_d    = k2_i;
                        n1_d    = '0;
                        n2_d    = '0;
                        acc_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready_o = (state_q == ACCUM);
    assign m_valid_o = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);
    assign m_data_o  = m_data_q;

endmodule : dct2d_coeff_mac
`default_nettype wire

// File: tb/tb_dct2d_coeff_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dct2d_coeff_mac
//  Purpose  : Self-checking bench for dct2d_coeff_mac (N=8, DATA_W=8,
//             FRAC_BITS=8, LEVEL_SHIFT=1). Expected coefficients are queued
//             when a block is started and popped when the result appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dct2d_coeff_mac;

    localparam int  N         = 8;
    localparam int  DATA_W    = 8;
    localparam int  FRAC_BITS = 8;
    localparam int  LOG2N     = 3;
    localparam int  OUT_W     = 17;
    localparam int  NPIX      = N * N;
    localparam real PI        = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [LOG2N-1:0]        k1 = '0;
    logic [LOG2N-1:0]        k2 = '0;
    logic                    busy;
    logic                    s_valid = 1'b0;
    logic [DATA_W-1:0]       s_data = '0;
    logic                    s_ready;
    logic                    m_valid;
    logic signed [OUT_W-1:0] m_data;
    logic                    m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int pix [NPIX];
    int exp_q [$];

    dct2d_coeff_mac #(
        .N           (N),
        .DATA_W      (DATA_W),
        .FRAC_BITS   (FRAC_BITS),
        .LEVEL_SHIFT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .k1_i      (k1),
        .k2_i      (k2),
        .busy_o    (busy),
        .s_valid_i (s_valid),
        .s_data_i  (s_data),
        .s_ready_o (s_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    // Reference cosine product, scaled by 2^8 and taken toward zero.
    function automatic int model_cos(int a1, int a2, int b1, int b2);
        real v;
        v = $cos($itor((2 * b1 + 1) * a1) * PI / 16.0) *
            $cos($itor((2 * b2 + 1) * a2) * PI / 16.0) * 256.0;
        if (v >= 0.0) return $rtoi(v + 1.0e-9);
        return -$rtoi(-v + 1.0e-9);
    endfunction

    function automatic int model_coeff(int a1, int a2);
        longint acc = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc += longint'(pix[r * N + c] - 128) * longint'(model_cos(a1, a2, r, c));
        return int'((acc + 128) >>> 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE and queue the value the block must produce.
    task automatic start_block(int a1, int a2, int expected);
        start = 1'b1;
        k1    = LOG2N'(a1);
        k2    = LOG2N'(a2);
        exp_q.push_back(expected);
        tick();
        start = 1'b0;
    endtask

    // Feed pix[first..last-1]; with gaps, idle cycles carry junk data.
    task automatic feed(int first, int last, bit gaps);
        for (int i = first; i < last; i++) begin
            int g;
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                s_valid = 1'b0;
                s_data  = DATA_W'($urandom);
                tick();
            end
            s_valid = 1'b1;
            s_data  = DATA_W'(pix[i]);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic release_result();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dc_flat();
        int e;
        for (int i = 0; i < NPIX; i++) pix[i] = 255;
        start_block(0, 0, 8128);
        n_checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL dc_start_ready: got s_ready=%b busy=%b want 1/1", s_ready, busy); end
        feed(0, NPIX, 1'b0);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL dc_latency: got m_valid=%b want 1", m_valid); end
        e = exp_q.pop_front();
        n_checks++; if (m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL dc_value: got %0d want %0d", m_data, e); end
        release_result();
        n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dc_to_idle: got m_valid=%b busy=%b want 0/0", m_valid, busy); end
    endtask

    task automatic test_flat_ac();
        int e;
        for (int i = 0; i < NPIX; i++) pix[i] = 200;
        start_block(2, 6, 0);
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_valid !== 1'b1 || m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL flat_ac: got valid=%b data=%0d want 1/%0d", m_valid, m_data, e); end
        release_result();
    endtask

    task automatic test_impulse();
        int e;
        for (int i = 0; i < NPIX; i++) pix[i] = 128;
        pix[0] = 228;
        start_block(2, 6, 35);
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL impulse_26: got %0d want %0d", m_data, e); end
        release_result();
        start_block(0, 1, model_coeff(0, 1));
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL impulse_01: got %0d want %0d", m_data, e); end
        release_result();
        // An impulse at an odd position exercises odd n1/n2 indexing.
        pix[0] = 128;
        pix[3 * N + 5] = 20;
        start_block(5, 3, model_coeff(5, 3));
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL impulse_53: got %0d want %0d", m_data, e); end
        release_result();
    endtask

    task automatic test_stall();
        int e;
        int bad_hold = 0;
        for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
        start_block(3, 5, model_coeff(3, 5));
        feed(0, NPIX, 1'b1);
        e = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            start = 1'b1;
            k1    = 3'd7;
            n_checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || m_data !== OUT_W'(e)) begin
                n_fail++;
                bad_hold++;
                if (bad_hold <= 3)
                    $display("FAIL stall_hold[%0d]: got valid=%b ready=%b busy=%b data=%0d want 1/0/1/%0d",
                             c, m_valid, s_ready, busy, m_data, e);
            end
            tick();
        end
        start = 1'b0;
        release_result();
        // Same block without gaps must give the same coefficient.
        start_block(3, 5, model_coeff(3, 5));
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL stall_ungapped: got %0d want %0d", m_data, e); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int e;
        for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
        start_block(1, 2, model_coeff(1, 2));
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_valid !== 1'b1 || m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL b2b_first: got valid=%b data=%0d want 1/%0d", m_valid, m_data, e); end
        for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
        m_ready = 1'b1;
        start   = 1'b1;
        k1      = 3'd6;
        k2      = 3'd7;
        exp_q.push_back(model_coeff(6, 7));
        tick();
        m_ready = 1'b0;
        start   = 1'b0;
        k1      = 3'd0;
        k2      = 3'd0;
        n_checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_idle: got s_ready=%b m_valid=%b want 1/0", s_ready, m_valid); end
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_valid !== 1'b1 || m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL b2b_second: got valid=%b data=%0d want 1/%0d", m_valid, m_data, e); end
        release_result();
    endtask

    task automatic test_reset_mid_block();
        int e;
        int seen = 0;
        for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
        start = 1'b1;
        k1    = 3'd0;
        k2    = 3'd0;
        tick();
        start = 1'b0;
        feed(0, 30, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b valid=%b busy=%b data=%0d want 0/0/0/0", s_ready, m_valid, busy, m_data);
        end
        tick();
        rst = 1'b0;
        // Remaining pixels arrive anyway; an idle engine must ignore them.
        for (int i = 30; i < NPIX + 8; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'($urandom);
            tick();
            if (m_valid !== 1'b0 || s_ready !== 1'b0) seen++;
        end
        s_valid = 1'b0;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles want 0", seen); end
        for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
        start_block(4, 4, model_coeff(4, 4));
        feed(0, NPIX, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (m_valid !== 1'b1 || m_data !== OUT_W'(e)) begin n_fail++; $display("FAIL midreset_fresh: got valid=%b data=%0d want 1/%0d", m_valid, m_data, e); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_dc_flat();
        test_flat_ac();
        test_impulse();
        test_stall();
        test_back_to_back();
        test_reset_mid_block();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dct2d_coeff_mac
`default_nettype wire
